// File: rtl/cache_fill_ctrl.sv
// Cache fill controller: serves reads from a downstream cache, fills misses from
// memory, and writes through to memory before updating the cache line.
`timescale 1ns/1ps

module cache_fill_ctrl #(
  parameter int ADDR_WIDTH   = 8,
  parameter int LINE_WIDTH   = 32,
  parameter int FILL_TIMEOUT = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LINE_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [LINE_WIDTH-1:0] resp_data,
  output logic                  resp_hit,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] c_addr,
  output logic [LINE_WIDTH-1:0] c_val,
  output logic                  c_read,
  output logic                  c_write,
  input  logic                  c_hit,
  input  logic [LINE_WIDTH-1:0] c_out_val,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_write,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [LINE_WIDTH-1:0] mem_req_wdata,
  input  logic                  mem_resp_valid,
  input  logic [LINE_WIDTH-1:0] mem_resp_data
);

  localparam int CNT_W = $clog2(FILL_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, CHECK, MEM_REQ, MEM_WAIT, FILL, RESP
  } state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [LINE_WIDTH-1:0]   wdata_q;
  logic                    write_q;
  logic [LINE_WIDTH-1:0]   line_q;
  logic [CNT_W-1:0]        fill_cnt;
  logic                    fill_done;
  logic                    fill_tmo;

  // The cache and memory see the latched request for the whole transaction.
  assign c_addr        = addr_q;
  assign c_val         = line_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_write = write_q;

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt     = state;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    c_read        = 1'b0;
    c_write       = 1'b0;
    mem_req_valid = 1'b0;
    fill_done     = 1'b0;
    fill_tmo      = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = req_write ? MEM_REQ : LOOKUP;
      end
      LOOKUP: begin
        c_read    = 1'b1;
        state_nxt = CHECK;
      end
      CHECK: state_nxt = c_hit ? RESP : MEM_REQ;
      MEM_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_nxt = MEM_WAIT;
      end
      MEM_WAIT: if (mem_resp_valid) state_nxt = FILL;
      FILL: begin
        c_write = 1'b1;
        // c_hit in the first FILL cycle predates any write edge, so it is ignored.
        fill_done = c_hit && (fill_cnt != '0);
        fill_tmo  = (fill_cnt == CNT_W'(FILL_TIMEOUT - 1));
        if (fill_done || fill_tmo) state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      line_q    <= '0;
      fill_cnt  <= '0;
      resp_data <= '0;
      resp_hit  <= 1'b0;
      resp_err  <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        write_q <= req_write;
      end
      if (state == CHECK && c_hit) begin
        resp_data <= c_out_val;
        resp_hit  <= 1'b1;
      end
      // A write response is only an acknowledgement; the line is the write data.
      if (state == MEM_WAIT && mem_resp_valid)
        line_q <= write_q ? wdata_q : mem_resp_data;
      fill_cnt <= (state == FILL) ? fill_cnt + CNT_W'(1) : '0;
      if (state == FILL && (fill_done || fill_tmo)) begin
        resp_data <= line_q;
        resp_hit  <= 1'b0;
        resp_err  <= !fill_done;
      end
      if (state == RESP && resp_ready) begin
        resp_hit <= 1'b0;
        resp_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Bench for cache_fill_ctrl: cache and memory responder models, a directed
// vector table, mid-transaction reset, and randomized traffic vs a reference model.
`timescale 1ns/1ps

module tb_cache_fill_ctrl;
  localparam int AW = 8;
  localparam int LW = 32;
  localparam int FT = 8;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [LW-1:0] req_wdata = '0;
  logic          resp_valid, resp_ready = 1'b0, resp_hit, resp_err;
  logic [LW-1:0] resp_data;
  logic [AW-1:0] c_addr;
  logic [LW-1:0] c_val, c_out_val;
  logic          c_read, c_write, c_hit;
  logic          mem_req_valid, mem_req_ready, mem_req_write;
  logic [AW-1:0] mem_req_addr;
  logic [LW-1:0] mem_req_wdata, mem_resp_data;
  logic          mem_resp_valid;

  always #5 clock = ~clock;

  cache_fill_ctrl #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .FILL_TIMEOUT(FT)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_hit(resp_hit), .resp_err(resp_err),
    .c_addr(c_addr), .c_val(c_val), .c_read(c_read), .c_write(c_write),
    .c_hit(c_hit), .c_out_val(c_out_val),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data)
  );

  int checks = 0;
  int failures = 0;

  // Environment knobs, driven only from the main initial block.
  int   rd_delay = 0;   // cycles mem_req_valid waits before mem_req_ready
  int   rl_delay = 1;   // edges from handshake until mem_resp_valid is raised
  int   fill_lat = 1;   // write edges before the cache reports c_hit
  bit   fill_blk = 1'b0;
  bit   spur_rv  = 1'b0;
  bit   pre_en   = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [LW-1:0] pre_data = '0;
  bit   busy   = 1'b0;
  bit   mon_en = 1'b0;

  function automatic logic [LW-1:0] init_line(input logic [AW-1:0] a);
    case (a)
      8'h20:   return 32'h1234_5678;
      8'h40:   return 32'hA5A5_0040;
      8'h50:   return 32'h0BAD_0050;
      default: return {~a, a, 16'h5A3C};
    endcase
  endfunction

  // Cache model: hit/out_val registered one edge after read/write.
  logic [LW-1:0] c_arr [256];
  bit            c_vld [256];
  int            wr_cnt = 0;
  logic          c_hit_r = 1'b0;
  logic [LW-1:0] c_out_r = '0;
  assign c_hit     = c_hit_r;
  assign c_out_val = c_out_r;

  always @(posedge clock) begin
    if (pre_en) begin
      c_arr[pre_addr] <= pre_data;
      c_vld[pre_addr] <= 1'b1;
    end
    if (c_read) begin
      c_hit_r <= c_vld[c_addr];
      c_out_r <= c_arr[c_addr];
      wr_cnt  <= 0;
    end else if (c_write) begin
      if (!fill_blk && wr_cnt + 1 >= fill_lat) begin
        c_hit_r         <= 1'b1;
        c_arr[c_addr]   <= c_val;
        c_vld[c_addr]   <= 1'b1;
      end else begin
        c_hit_r <= 1'b0;
      end
      wr_cnt <= wr_cnt + 1;
    end else begin
      c_hit_r <= 1'b0;
      wr_cnt  <= 0;
    end
  end

  // Memory model: not reset with the DUT, so a pending response survives reset.
  logic [LW-1:0] m_arr [256];
  bit            m_wv  [256];
  int            wait_cnt = 0, rtimer = 0, hs_cnt = 0, late_cnt = 0;
  bit            pend = 1'b0;
  logic          mrv_model = 1'b0;
  logic [LW-1:0] pend_data = '0, mdata = '0;
  logic [AW-1:0] hs_addr = '0;
  logic          hs_write = 1'b0;
  logic [LW-1:0] hs_wdata = '0;

  assign mem_req_ready  = (wait_cnt >= rd_delay);
  assign mem_resp_valid = mrv_model | spur_rv;
  assign mem_resp_data  = spur_rv ? 32'hBADB_AD00 : mdata;

  always @(posedge clock) begin
    mrv_model <= 1'b0;
    if (mem_req_valid && mem_req_ready) begin
      wait_cnt <= 0;
      hs_cnt   <= hs_cnt + 1;
      hs_addr  <= mem_req_addr;
      hs_write <= mem_req_write;
      hs_wdata <= mem_req_wdata;
      if (mem_req_write) begin
        m_arr[mem_req_addr] <= mem_req_wdata;
        m_wv[mem_req_addr]  <= 1'b1;
        pend_data           <= ~mem_req_wdata;  // garbage the DUT must ignore
      end else begin
        pend_data <= m_wv[mem_req_addr] ? m_arr[mem_req_addr] : init_line(mem_req_addr);
      end
      pend   <= 1'b1;
      rtimer <= rl_delay;
    end else begin
      wait_cnt <= mem_req_valid ? wait_cnt + 1 : 0;
      if (pend) begin
        if (rtimer <= 1) begin
          mrv_model <= 1'b1;
          mdata     <= pend_data;
          pend      <= 1'b0;
          late_cnt  <= late_cnt + 1;
        end else begin
          rtimer <= rtimer - 1;
        end
      end
    end
  end

  // Cycle monitor: cumulative event and violation counters, sampled mid-cycle.
  int n_cread = 0, n_cwrite = 0, n_mrv = 0, n_clash = 0, n_rdy_bad = 0, n_unst = 0;
  logic          pv_mv = 1'b0, pv_mr = 1'b0, pv_mw = 1'b0, pv_cw = 1'b0;
  logic [AW-1:0] pv_ma = '0, pv_ca = '0;
  logic [LW-1:0] pv_md = '0, pv_cv = '0;

  always @(negedge clock) begin
    if (!mon_en) begin
      pv_mv <= 1'b0;
      pv_cw <= 1'b0;
    end else begin
      if (c_read)        n_cread  <= n_cread + 1;
      if (c_write)       n_cwrite <= n_cwrite + 1;
      if (mem_req_valid) n_mrv    <= n_mrv + 1;
      if (c_read && c_write) n_clash <= n_clash + 1;
      if (req_ready !== !busy) n_rdy_bad <= n_rdy_bad + 1;
      if ((pv_mv && !pv_mr && !(mem_req_valid && mem_req_addr == pv_ma &&
           mem_req_write == pv_mw && mem_req_wdata == pv_md)) ||
          (pv_cw && c_write && (c_addr != pv_ca || c_val != pv_cv)))
        n_unst <= n_unst + 1;
      pv_mv <= mem_req_valid; pv_mr <= mem_req_ready; pv_mw <= mem_req_write;
      pv_ma <= mem_req_addr;  pv_md <= mem_req_wdata;
      pv_cw <= c_write; pv_ca <= c_addr; pv_cv <= c_val;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_state(input string name);
    check({name, " ctrl outputs"},
          {req_ready, resp_valid, resp_hit, resp_err, c_read, c_write, mem_req_valid, mem_req_write},
          8'b1000_0000);
    check({name, " resp_data"}, resp_data, 0);
    check({name, " c_addr"}, c_addr, 0);
    check({name, " c_val"}, c_val, 0);
    check({name, " mem_req_addr"}, mem_req_addr, 0);
    check({name, " mem_req_wdata"}, mem_req_wdata, 0);
  endtask

  // Reference model: the cache and memory contents as the requester sees them.
  logic [LW-1:0] r_mem [256];
  bit            r_mwv [256];
  logic [LW-1:0] r_c   [256];
  bit            r_cv  [256];

  task automatic ref_txn(input bit w, input logic [AW-1:0] a, input logic [LW-1:0] d,
                         input bit blk, input int fl,
                         output logic [LW-1:0] ed, output bit eh, output bit ee);
    bit tmo;
    tmo = blk || (fl + 1 > FT);
    if (!w && r_cv[a]) begin
      ed = r_c[a]; eh = 1'b1; ee = 1'b0;
    end else begin
      if (w) begin
        r_mem[a] = d;
        r_mwv[a] = 1'b1;
      end
      ed = w ? d : (r_mwv[a] ? r_mem[a] : init_line(a));
      eh = 1'b0;
      ee = tmo;
      if (!tmo) begin
        r_cv[a] = 1'b1;
        r_c[a]  = ed;
      end
    end
  endtask

  task automatic run_txn(input string name, input bit w, input logic [AW-1:0] a,
                         input logic [LW-1:0] d, input int rd, input int rl, input int fl,
                         input bit blk, input int hold,
                         input logic [LW-1:0] ed, input bit eh, input bit ee);
    int n, fc, lat, s_cr, s_cw, s_mrv, s_clash, s_rdy, s_unst, s_hs;
    bit done;
    @(negedge clock);
    rd_delay = rd; rl_delay = rl; fill_lat = fl; fill_blk = blk;
    check({name, " req_ready in idle"}, req_ready, 1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    @(posedge clock); #1;
    busy = 1'b1;
    s_cr = n_cread; s_cw = n_cwrite; s_mrv = n_mrv; s_clash = n_clash;
    s_rdy = n_rdy_bad; s_unst = n_unst; s_hs = hs_cnt;
    // A competing request held while busy must not be latched.
    req_write = 1'($urandom); req_addr = ~a; req_wdata = $urandom;
    n = 0; done = 1'b0;
    while (!done && n < 200) begin
      @(posedge clock); n++;
      @(negedge clock); done = resp_valid;
    end
    req_valid = 1'b0;
    check({name, " resp_valid reached"}, done, 1);
    fc  = (blk || fl + 1 > FT) ? FT : fl + 1;
    // Edges after the accept edge: a hit is LOOKUP+CHECK, so resp_valid follows
    // the 3rd edge counting acceptance.
    lat = eh ? 2 : (w ? 0 : 2) + (rd + 1) + (rl + 1) + fc;
    check({name, " latency"}, n, lat);
    check({name, " resp_data"}, resp_data, ed);
    check({name, " resp_hit/err"}, {resp_hit, resp_err}, {eh, ee});
    repeat (hold) begin
      @(posedge clock); @(negedge clock);
      check({name, " held resp"}, {resp_valid, resp_hit, resp_err, resp_data}, {1'b1, eh, ee, ed});
    end
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    busy = 1'b0;
    check({name, " resp released"}, {resp_valid, resp_err, req_ready}, 3'b001);
    check({name, " c_read cycles"}, n_cread - s_cr, w ? 0 : 1);
    check({name, " c_write cycles"}, n_cwrite - s_cw, eh ? 0 : fc);
    check({name, " mem_req_valid cycles"}, n_mrv - s_mrv, eh ? 0 : rd + 1);
    check({name, " mem handshakes"}, hs_cnt - s_hs, eh ? 0 : 1);
    if (!eh) check({name, " mem req addr/write"}, {hs_addr, hs_write}, {a, w});
    if (w)   check({name, " mem req wdata"}, hs_wdata, d);
    check({name, " interlock/ready/stability"},
          {n_clash - s_clash, n_rdy_bad - s_rdy, n_unst - s_unst}, 0);
  endtask

  typedef struct {
    string         name;
    bit            w;
    logic [AW-1:0] a;
    logic [LW-1:0] d;
    int            rd, rl, fl;
    bit            blk;
    int            hold;
    logic [LW-1:0] ed;
    bit            eh, ee;
  } vec_t;

  initial begin
    vec_t          tbl [10];
    logic [LW-1:0] ed;
    bit            eh, ee;
    int            s_hs, s_late, n;

    #1;
    check_reset_state("power-on reset");
    repeat (3) @(negedge clock);
    #2 reset_n = 1'b1;
    #1 mon_en = 1'b1;

    @(negedge clock);
    pre_en = 1'b1; pre_addr = 8'h10; pre_data = 32'hDEAD_BEEF;
    r_c[8'h10] = 32'hDEAD_BEEF; r_cv[8'h10] = 1'b1;
    @(negedge clock);
    pre_en = 1'b0;

    //          name                    w  addr   wdata         rd rl fl blk hold expected      hit err
    tbl[0] = '{"read hit 0x10",         0, 8'h10, 32'h0,        0, 1, 1, 0,  5, 32'hDEAD_BEEF, 1, 0};
    tbl[1] = '{"read miss 0x20",        0, 8'h20, 32'h0,        2, 3, 1, 0,  0, 32'h1234_5678, 0, 0};
    tbl[2] = '{"write 0x30",            1, 8'h30, 32'hCAFE_F00D,0, 1, 2, 0,  0, 32'hCAFE_F00D, 0, 0};
    tbl[3] = '{"read after write 0x30", 0, 8'h30, 32'h0,        0, 1, 1, 0,  1, 32'hCAFE_F00D, 1, 0};
    tbl[4] = '{"fill never hits 0x40",  0, 8'h40, 32'h0,        1, 2, 1, 1,  0, 32'hA5A5_0040, 0, 1};
    tbl[5] = '{"fill hit last cycle",   0, 8'h40, 32'h0,        0, 1, 7, 0,  0, 32'hA5A5_0040, 0, 0};
    tbl[6] = '{"fill hit one too late", 0, 8'h50, 32'h0,        0, 1, 8, 0,  2, 32'h0BAD_0050, 0, 1};
    tbl[7] = '{"read hit 0x20",         0, 8'h20, 32'h0,        0, 1, 1, 0,  0, 32'h1234_5678, 1, 0};
    tbl[8] = '{"write over line 0x20",  1, 8'h20, 32'h55AA_1234,3, 2, 1, 0,  0, 32'h55AA_1234, 0, 0};
    tbl[9] = '{"read hit new 0x20",     0, 8'h20, 32'h0,        0, 1, 1, 0,  0, 32'h55AA_1234, 1, 0};

    for (int i = 0; i < 10; i++) begin
      ref_txn(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].blk, tbl[i].fl, ed, eh, ee);
      run_txn(tbl[i].name, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].rd, tbl[i].rl,
              tbl[i].fl, tbl[i].blk, tbl[i].hold, tbl[i].ed, tbl[i].eh, tbl[i].ee);
    end

    // Reset while waiting on memory: transaction abandoned, late response ignored.
    @(negedge clock);
    rd_delay = 0; rl_delay = 8; fill_lat = 1; fill_blk = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h60; req_wdata = 32'h0;
    @(posedge clock); #1;
    busy = 1'b1; req_valid = 1'b0;
    s_hs = hs_cnt; s_late = late_cnt; n = 0;
    while (hs_cnt == s_hs && n < 50) begin
      @(posedge clock); #1; n++;
    end
    check("mid-txn reset: mem handshake seen", hs_cnt - s_hs, 1);
    @(negedge clock); #2;
    mon_en = 1'b0; busy = 1'b0; reset_n = 1'b0;
    #1;
    check_reset_state("mid-txn reset");
    @(negedge clock); #2;
    reset_n = 1'b1;
    #1 mon_en = 1'b1;
    repeat (12) begin
      @(negedge clock);
      check("post-reset idle", {resp_valid, mem_req_valid, c_read, c_write, req_ready}, 5'b00001);
    end
    check("post-reset late response delivered", late_cnt - s_late, 1);
    check("post-reset line untouched", {c_val, resp_data}, 0);
    @(negedge clock); spur_rv = 1'b1;
    @(negedge clock); spur_rv = 1'b0;
    @(negedge clock);
    check("spurious mem_resp in idle", {resp_valid, c_write, req_ready, c_val}, {3'b001, 32'h0});

    ref_txn(1'b0, 8'h60, 32'h0, 1'b0, 2, ed, eh, ee);
    run_txn("read 0x60 after reset", 1'b0, 8'h60, 32'h0, 1, 1, 2, 1'b0, 0, ed, eh, ee);

    // Randomized traffic over a small address window so lines get reused.
    for (int i = 0; i < 40; i++) begin
      bit            w, blk;
      logic [AW-1:0] a;
      logic [LW-1:0] d;
      int            rd, rl, fl, hold;
      w    = ($urandom_range(0, 9) < 4);
      a    = 8'h80 + 8'($urandom_range(0, 15));
      d    = $urandom;
      rd   = $urandom_range(0, 3);
      rl   = $urandom_range(1, 4);
      fl   = $urandom_range(1, 5);
      blk  = ($urandom_range(0, 7) == 0);
      hold = $urandom_range(0, 2);
      ref_txn(w, a, d, blk, fl, ed, eh, ee);
      run_txn($sformatf("rand %0d", i), w, a, d, rd, rl, fl, blk, hold, ed, eh, ee);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cache_fill_ctrl.md
CACHE_FILL_CTRL -- requirements
Module: cache_fill_ctrl

Interface
REQ-001 The block SHALL have parameters: ADDR_WIDTH, default 8, address width; LINE_WIDTH, default 32, data line width; FILL_TIMEOUT, default 8, maximum cycles of cache write-hold before error.
REQ-002 The block SHALL have a single clock and an asynchronous, active-low reset; the ports are listed below, clock and reset first.
REQ-003 clock  in  1  sole clock; all state changes on posedge.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 req_valid/req_ready  in/out  1/1  requester handshake; req_write  in  1  1=write, 0=read; req_addr  in  ADDR_WIDTH; req_wdata  in  LINE_WIDTH.
REQ-006 resp_valid  out  1; resp_ready  in  1; resp_data  out  LINE_WIDTH; resp_hit  out  1 (request served from cache); resp_err  out  1 (fill timeout).
REQ-007 c_addr  out  ADDR_WIDTH; c_val  out  LINE_WIDTH; c_read  out  1; c_write  out  1; c_hit  in  1; c_out_val  in  LINE_WIDTH; all connect to the cache downstream, whose hit and out_val are registered one edge after read/write.
REQ-008 mem_req_valid  out  1; mem_req_ready  in  1; mem_req_write  out  1; mem_req_addr  out  ADDR_WIDTH; mem_req_wdata  out  LINE_WIDTH; mem_resp_valid  in  1; mem_resp_data  in  LINE_WIDTH.

Function
REQ-009 The FSM SHALL have states IDLE, LOOKUP, CHECK, MEM_REQ, MEM_WAIT, FILL, RESP.
REQ-010 req_ready SHALL be 1 only in IDLE; a request is accepted on an edge where req_valid && req_ready, latching addr, wdata, and write into internal registers.
REQ-011 On an accepted read: IDLE->LOOKUP; in LOOKUP, c_read=1 for exactly one cycle with c_addr=latched addr; then ->CHECK.
REQ-012 In CHECK (c_read=0), c_hit=1 SHALL latch resp_data=c_out_val, resp_hit=1, and go ->RESP; c_hit=0 SHALL go ->MEM_REQ with mem_req_write=0.
REQ-013 On an accepted write: IDLE->MEM_REQ with mem_req_write=1 and mem_req_wdata=latched wdata (write-through); the cache is then updated in FILL with the same data.
REQ-014 In MEM_REQ, mem_req_valid SHALL be held at 1 with stable addr/write/wdata until mem_req_ready=1, then ->MEM_WAIT; it SHALL not drop before ready.
REQ-015 In MEM_WAIT, the block SHALL wait indefinitely for mem_resp_valid; on a read, it latches line=mem_resp_data; on a write, line=latched wdata (the response is an acknowledgement only; its data is ignored); then ->FILL.
REQ-016 In FILL, c_write SHALL be held at 1 with c_addr/c_val stable; completion is c_hit=1 sampled in a cycle following a c_write=1 edge; on completion c_write drops in the next cycle and the state goes ->RESP with resp_data=line and resp_hit=0.
REQ-017 c_read and c_write SHALL never be 1 in the same cycle.
REQ-018 If FILL has lasted FILL_TIMEOUT cycles without completion, the block SHALL drop c_write, set resp_err=1, set resp_data=line, and go ->RESP.
REQ-019 In RESP, resp_valid=1 SHALL be held, with resp_data/resp_hit/resp_err stable, until resp_ready=1; then ->IDLE, with resp_err cleared.
REQ-020 A read that misses SHALL take 1 LOOKUP + 1 CHECK + mem handshake + memory latency + FILL cycles to reach RESP; a read that hits SHALL assert resp_valid on the 3rd edge after acceptance.
REQ-021 req_valid while not in IDLE SHALL be ignored (no latch); back-to-back requests SHALL be allowed (RESP->IDLE->accept on the following edge).
REQ-022 mem_resp_valid outside MEM_WAIT SHALL be ignored.

Reset
REQ-023 On reset_n=0, the block SHALL immediately go to IDLE, with req_ready=1 and resp_valid, resp_hit, resp_err, c_read, c_write, and mem_req_valid all 0; data/address outputs SHALL be 0.
REQ-024 Reset asserted mid-transaction SHALL abandon it with no response; any outstanding memory response after release SHALL be ignored per REQ-022.

Verification
REQ-025 Read hit: cache model holds 0x10=0xDEADBEEF; read 0x10 -> c_read for 1 cycle, no mem_req_valid, resp_valid with resp_data=0xDEADBEEF, resp_hit=1.
REQ-026 Read miss: read 0x20, memory returns 0x12345678 after 3 cycles, mem_req_ready delayed 2 cycles -> mem_req_valid held 3 cycles, c_write until c_hit, resp_data=0x12345678, resp_hit=0.
REQ-027 Write: write 0x30=0xCAFEF00D -> mem_req_write=1 with wdata 0xCAFEF00D, then FILL, then a subsequent read of 0x30 hits with 0xCAFEF00D.
REQ-028 Fill timeout: cache model never raises c_hit during FILL -> after 8 cycles c_write=0, resp_err=1, resp_data=line.
REQ-029 Backpressure and reset: resp_ready held at 0 for 5 cycles -> resp outputs stable; then reset_n pulsed during MEM_WAIT -> IDLE, outputs zero, a late mem_resp_valid is ignored.
REQ-030 Interlock: across all scenarios, c_read && c_write never occurs, and req_ready=0 outside IDLE.
